// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler
//   Generates the game-tick enable pulse from a programmable prescaler whose
//   period shrinks as the difficulty level rises. A small FSM handles
//   start, pause/resume and stop (game over).
//
//   Ports:
//     clk    in   system clock
//     rst    in   asynchronous, active-high reset
//     start  in   pulse: begin a new game (from IDLE or OVER)
//     pause  in   pulse: toggle RUN <-> PAUSE
//     stop   in   pulse: end the game (RUN/PAUSE -> OVER)
//     tick   out  one-cycle registered game-advance pulse
//     level  out  current difficulty level (held in OVER for score display)
//     state  out  IDLE=0, RUN=1, PAUSE=2, OVER=3
//     busy   out  high in RUN or PAUSE
//     sq_out out  ~50% duty square wave at the tick rate
//                 (only when TICK_SCHED_SQUARE_EN is defined)
//
//   Optional macro: TICK_SCHED_SQUARE_EN adds the sq_out port and its logic.
//   When two or more control pulses land on the same edge, stop wins over
//   pause, and pause wins over start.
module game_tick_scheduler #(
   parameter int CNT_W           = 20,
   parameter int BASE_PERIOD     = 1000000,
   parameter int STEP            = 100000,
   parameter int MIN_PERIOD      = 200000,
   parameter int TICKS_PER_LEVEL = 16,
   parameter int MAX_LEVEL       = 7,
   parameter int LVL_W           = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   output logic             tick,
   output logic [LVL_W-1:0] level,
   output logic [1:0]       state,
   output logic             busy
`ifdef TICK_SCHED_SQUARE_EN
   ,
   output logic             sq_out
`endif
);

   localparam int TC_W = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
   localparam int PW   = CNT_W + LVL_W;

   localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_PERIOD);
   localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
   localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PERIOD);
   localparam logic [TC_W-1:0]  TC_LAST = TC_W'(TICKS_PER_LEVEL - 1);
   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TC_W-1:0]  tc_q, tc_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             tick_q, tick_d;
   logic             busy_q, busy_d;

   // Period for the current level. The reduction is formed wide enough that
   // level*STEP never wraps, so a large reduction lands on the floor instead
   // of underflowing.
   logic [PW-1:0]    red;
   logic [CNT_W-1:0] diff;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] half;

   always_comb begin
      red  = PW'(level_q) * PW'(STEP_C);
      diff = BASE_C - red[CNT_W-1:0];
      if (red >= PW'(BASE_C) || diff < MIN_C)
         period = MIN_C;
      else
         period = diff;
      half = period >> 1;
   end

`ifdef TICK_SCHED_SQUARE_EN
   logic sq_q, sq_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tc_d    = tc_q;
      level_d = level_q;
      tick_d  = 1'b0;
`ifdef TICK_SCHED_SQUARE_EN
      sq_d    = sq_q;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d   = '0;
            tc_d    = '0;
            level_d = '0;
            if (start && !pause && !stop)
               state_d = S_RUN;
         end
         S_RUN: begin
            if (stop) begin
               state_d = S_OVER;
            end else if (pause) begin
               // Counting is suppressed on the pause edge, including a
               // would-be wrap; it completes on the first edge after resume.
               state_d = S_PAUSE;
            end else begin
               if (cnt_q == period - CNT_W'(1)) begin
                  cnt_d  = '0;
                  tick_d = 1'b1;
                  if (tc_q == TC_LAST) begin
                     tc_d = '0;
                     if (level_q < LVL_MAX)
                        level_d = level_q + LVL_W'(1);
                  end else begin
                     tc_d = tc_q + TC_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`ifdef TICK_SCHED_SQUARE_EN
               sq_d = (cnt_d >= half);
`endif
            end
         end
         S_PAUSE: begin
            if (stop)
               state_d = S_OVER;
            else if (pause)
               state_d = S_RUN;
         end
         default: begin // S_OVER: level stays visible until a new game
            if (start && !pause && !stop) begin
               state_d = S_RUN;
               cnt_d   = '0;
               tc_d    = '0;
               level_d = '0;
            end
         end
      endcase
      busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
`ifdef TICK_SCHED_SQUARE_EN
      if (state_d == S_IDLE || state_d == S_OVER)
         sq_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tc_q    <= '0;
         level_q <= '0;
         tick_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
         level_q <= level_d;
         tick_q  <= tick_d;
         busy_q  <= busy_d;
      end
   end

`ifdef TICK_SCHED_SQUARE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sq_q <= 1'b0;
      else
         sq_q <= sq_d;
   end
   assign sq_out = sq_q;
`endif

   assign tick  = tick_q;
   assign level = level_q;
   assign state = state_q;
   assign busy  = busy_q;

   // half is only consumed by the square-wave logic
   logic unused_half;
   assign unused_half = ^half;

endmodule

// File: tb/tb_game_tick_scheduler.sv
module tb_game_tick_scheduler;

   localparam int CNT_W = 8;
   localparam int BASE  = 8;
   localparam int STEPP = 2;
   localparam int MINP  = 4;
   localparam int TPL   = 2;
   localparam int MAXL  = 3;
   localparam int LVL_W = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0, pause = 1'b0, stop = 1'b0;
   logic             tick;
   logic [LVL_W-1:0] level;
   logic [1:0]       state;
   logic             busy;
`ifdef TICK_SCHED_SQUARE_EN
   logic             sq_out;
`endif

   int total = 0;
   int bad   = 0;

   game_tick_scheduler #(
      .CNT_W(CNT_W), .BASE_PERIOD(BASE), .STEP(STEPP), .MIN_PERIOD(MINP),
      .TICKS_PER_LEVEL(TPL), .MAX_LEVEL(MAXL), .LVL_W(LVL_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
      .tick(tick), .level(level), .state(state), .busy(busy)
`ifdef TICK_SCHED_SQUARE_EN
      , .sq_out(sq_out)
`endif
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Reference model: game mode, position within the current period, ticks
   // spent at this level, level, and the expected outputs.
   int m_state, m_cnt, m_tc, m_lvl, m_tick, m_sq;

   function automatic int per(input int l);
      int p;
      p = BASE - l * STEPP;
      if (p < MINP) p = MINP;
      return p;
   endfunction

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_tc = 0; m_lvl = 0; m_tick = 0; m_sq = 0;
   endtask

   task automatic model_step(input bit s, input bit p, input bit t);
      int pr;
      pr = per(m_lvl);
      m_tick = 0;
      case (m_state)
         0: if (s && !p && !t) begin m_state = 1; m_cnt = 0; end
         1: begin
            if (t) m_state = 3;
            else if (p) m_state = 2;
            else begin
               m_cnt = m_cnt + 1;
               if (m_cnt == pr) begin
                  m_cnt = 0;
                  m_tick = 1;
                  m_tc = m_tc + 1;
                  if (m_tc == TPL) begin
                     m_tc = 0;
                     if (m_lvl < MAXL) m_lvl = m_lvl + 1;
                  end
               end
               m_sq = (m_cnt >= pr / 2) ? 1 : 0;
            end
         end
         2: if (t) m_state = 3; else if (p) m_state = 1;
         default: if (s && !p && !t) begin
            m_state = 1; m_cnt = 0; m_tc = 0; m_lvl = 0;
         end
      endcase
      if (m_state == 0 || m_state == 3) m_sq = 0;
   endtask

   // One clock: drive pulses before the edge, sample 1ns after it.
   task automatic cyc(input bit s, input bit p, input bit t);
      @(negedge clk);
      start = s; pause = p; stop = t;
      @(posedge clk);
      #1;
      if (rst) model_reset(); else model_step(s, p, t);
      start = 0; pause = 0; stop = 0;
   endtask

   // Edges until tick shows, or -1 if none within the bound.
   task automatic wait_tick(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         cyc(0, 0, 0);
         if (tick === 1'b1) begin n = i; return; end
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      total++;
      if ({tick, level, state, busy} !== 6'b0) begin
         bad++;
         $display("FAIL reset_immediate: got tick=%b level=%0d state=%0d busy=%b want all 0",
                  tick, level, state, busy);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = $urandom_range(0, 1); pause = $urandom_range(0, 1); stop = $urandom_range(0, 1);
         if (i == 0) start = 1'b1;
         @(posedge clk);
         #1;
         total++;
         if ({tick, level, state, busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_hold: got tick=%b level=%0d state=%0d busy=%b want all 0",
                     tick, level, state, busy);
         end
      end
      @(negedge clk);
      start = 0; pause = 0; stop = 0; rst = 1'b0;
      model_reset();
   endtask

   task automatic test_levels();
      int n, exp_gap, exp_lvl;
      cyc(1, 0, 0);
      total++;
      if (state !== 2'd1 || busy !== 1'b1 || tick !== 1'b0) begin
         bad++;
         $display("FAIL start_run: got state=%0d busy=%b tick=%b want 1 1 0", state, busy, tick);
      end
      for (int k = 1; k <= 12; k++) begin
         exp_lvl = (k / TPL > MAXL) ? MAXL : k / TPL;
         exp_gap = per((k - 1) / TPL);
         wait_tick(n);
         total++;
         if (n != exp_gap) begin
            bad++;
            $display("FAIL tick_gap[%0d]: got %0d edges want %0d", k, n, exp_gap);
         end
         total++;
         if (level !== LVL_W'(exp_lvl)) begin
            bad++;
            $display("FAIL level_after_tick[%0d]: got %0d want %0d", k, level, exp_lvl);
         end
      end
   endtask

   task automatic test_pause();
      int n;
      cyc(0, 0, 1);
      total++;
      if (state !== 2'd3 || level !== 2'd3 || busy !== 1'b0) begin
         bad++;
         $display("FAIL stop_over: got state=%0d level=%0d busy=%b want 3 3 0", state, level, busy);
      end
      cyc(1, 0, 0);
      total++;
      if (state !== 2'd1 || level !== 2'd0) begin
         bad++;
         $display("FAIL restart: got state=%0d level=%0d want 1 0", state, level);
      end
      repeat (3) cyc(0, 0, 0);
      cyc(0, 1, 0);
      total++;
      if (state !== 2'd2 || busy !== 1'b1) begin
         bad++;
         $display("FAIL pause_enter: got state=%0d busy=%b want 2 1", state, busy);
      end
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0);
         total++;
         if (state !== 2'd2 || tick !== 1'b0) begin
            bad++;
            $display("FAIL paused[%0d]: got state=%0d tick=%b want 2 0", i, state, tick);
         end
      end
      cyc(0, 1, 0);
      total++;
      if (state !== 2'd1) begin
         bad++;
         $display("FAIL resume: got state=%0d want 1", state);
      end
      wait_tick(n);
      total++;
      if (n != 5) begin
         bad++;
         $display("FAIL resume_tick: got %0d edges want 5", n);
      end
   endtask

   task automatic test_priority();
      int n;
      wait_tick(n);
      total++;
      if (n != 8 || level !== 2'd1) begin
         bad++;
         $display("FAIL pre_prio_tick: got gap=%0d level=%0d want 8 1", n, level);
      end
      cyc(0, 0, 0);
      cyc(1, 1, 1);
      total++;
      if (state !== 2'd3 || tick !== 1'b0 || level !== 2'd1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL all_pulses: got state=%0d tick=%b level=%0d busy=%b want 3 0 1 0",
                  state, tick, level, busy);
      end
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0);
         total++;
         if (state !== 2'd3 || tick !== 1'b0 || level !== 2'd1) begin
            bad++;
            $display("FAIL over_hold[%0d]: got state=%0d tick=%b level=%0d want 3 0 1",
                     i, state, tick, level);
         end
      end
      cyc(1, 0, 0);
      total++;
      if (state !== 2'd1 || level !== 2'd0) begin
         bad++;
         $display("FAIL over_restart: got state=%0d level=%0d want 1 0", state, level);
      end
      wait_tick(n);
      total++;
      if (n != 8) begin
         bad++;
         $display("FAIL over_first_tick: got %0d edges want 8", n);
      end
   endtask

   task automatic test_async_reset();
      repeat (3) cyc(0, 0, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({tick, level, state, busy} !== 6'b0) begin
         bad++;
         $display("FAIL async_reset: got tick=%b level=%0d state=%0d busy=%b want all 0",
                  tick, level, state, busy);
      end
`ifdef TICK_SCHED_SQUARE_EN
      total++;
      if (sq_out !== 1'b0) begin
         bad++;
         $display("FAIL async_reset_sq: got %b want 0", sq_out);
      end
`endif
      model_reset();
      @(negedge clk);
      rst = 1'b0;
`ifdef TICK_SCHED_SQUARE_EN
      cyc(1, 0, 0);
      for (int k = 1; k <= 16; k++) begin
         cyc(0, 0, 0);
         total++;
         if (sq_out !== (((k % 8) >= 4) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL square[%0d]: got %b want %b", k, sq_out, ((k % 8) >= 4));
         end
      end
      repeat (5) cyc(0, 0, 0);
      cyc(0, 0, 1);
      total++;
      if (sq_out !== 1'b0 || state !== 2'd3) begin
         bad++;
         $display("FAIL square_over: got sq=%b state=%0d want 0 3", sq_out, state);
      end
`endif
   endtask

   task automatic test_random();
      bit s, p, t;
      logic [5:0] exp;
      for (int i = 0; i < 600; i++) begin
         s = ($urandom_range(0, 7) == 0);
         p = ($urandom_range(0, 11) == 0);
         t = ($urandom_range(0, 39) == 0);
         cyc(s, p, t);
         exp = {m_tick[0], LVL_W'(m_lvl), 2'(m_state), (m_state == 1 || m_state == 2)};
         total++;
         if ({tick, level, state, busy} !== exp) begin
            bad++;
            $display("FAIL random[%0d]: got tick=%b level=%0d state=%0d busy=%b want %b %0d %0d %b",
                     i, tick, level, state, busy, exp[5], exp[4:3], exp[2:1], exp[0]);
         end
`ifdef TICK_SCHED_SQUARE_EN
         total++;
         if (sq_out !== m_sq[0]) begin
            bad++;
            $display("FAIL random_sq[%0d]: got %b want %0d", i, sq_out, m_sq);
         end
`endif
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_levels();
      test_pause();
      test_priority();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
